add_4b_arb: RTL and testbench
=============================

ADD_4B_ARB -- requirements
Module: add_4b_arb

Interface
Parameters: none; operand width fixed at 4 bits, requester count fixed at 2.
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an add pending.
REQ-005 req0_x, req0_y  input  4 each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has an add pending.
REQ-008 req1_x, req1_y  input  4 each  requester 1 operands.
REQ-009 req1_ready  output  1  requester 1 operands accepted this cycle.
REQ-010 res_valid  output  1  result register holds an undelivered result.
REQ-011 res_ready  input  1  consumer accepts the result this cycle.
REQ-012 res_sum  output  4  registered sum.
REQ-013 res_id  output  1  index of the requester that owns res_sum.

Function
REQ-014 The block SHALL contain exactly one add_4b instance, shared by both requesters, with its operands driven by the granted requester's x/y.
REQ-015 Sum SHALL be (x + y) mod 16; the carry is discarded and no overflow flag exists.
REQ-016 FSM states SHALL be IDLE (result register empty) and HOLD (result register full).
REQ-017 Accept condition: slot_free = (state == IDLE) or (state == HOLD and res_ready).
REQ-018 reqN_ready SHALL be combinational: slot_free and requester N granted; at most one ready high per cycle.
REQ-019 Grant, only one valid: that requester is granted, regardless of priority.
REQ-020 Grant, both valid: the requester not served last is granted (round-robin via 1-bit last_id register).
REQ-021 Neither valid: no grant, both ready low.
REQ-022 On handshake (reqN_valid and reqN_ready) at edge k: res_sum, res_id and last_id SHALL be loaded, and res_valid SHALL be 1 from edge k; latency 1 cycle.
REQ-023 HOLD with res_ready and a new handshake in the same cycle: the register SHALL be reloaded and the state SHALL stay HOLD; sustained throughput 1 result/cycle.
REQ-024 HOLD with res_ready and no handshake: state SHALL go to IDLE and res_valid SHALL drop.
REQ-025 HOLD without res_ready: res_sum, res_id and res_valid SHALL hold, and both reqN_ready SHALL be 0.
REQ-026 Requesters SHALL hold valid and operands stable until ready; the block SHALL NOT latch operands before the handshake.
REQ-027 Grant SHALL be combinational from the current valids and last_id; a requester dropping valid before ready is never served and last_id is unchanged.

Reset
REQ-028 While rst_n = 0: state IDLE, res_valid 0, res_sum 0000, res_id 0, last_id 1 (requester 0 wins the first tie).
REQ-029 Reset assertion in HOLD SHALL discard the pending result immediately, with no delivery after release.
REQ-030 First handshake possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Single requester: req0 x=1000, y=1001, res_ready=1 -> req0_ready=1 the same cycle; next cycle res_valid=1, res_sum=0001, res_id=0.
REQ-032 Wrap-around: req1 x=1101, y=0110 -> res_sum=0011, res_id=1; x=1111, y=0001 -> res_sum=0000.
REQ-033 Tie after reset: both valid (req0 2+3, req1 4+5), res_ready=1 -> results 0101 id0, then 1001 id1 on consecutive cycles; the third tie goes to req0.
REQ-034 Backpressure: res_ready=0 for 3 cycles with both valid -> res_sum/res_id frozen, both ready 0; res_ready=1 -> pending result delivered and the next request accepted the same cycle.
REQ-035 Reset in HOLD: result pending, rst_n pulsed low mid-cycle -> res_valid 0 immediately and state IDLE; after release req0 wins a tie.
REQ-036 Starvation check: req0 held valid continuously, req1 valid intermittently -> every req1 request is served within 2 accept slots.

Source files
------------

// File: rtl/add_4b_arb.sv
// Two-requester round-robin front end sharing one 4-bit adder, with a single
// registered result slot that supports back-to-back accept and delivery.

module add_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum
);

    // Carry out is intentionally dropped: the result is modulo 16.
    assign sum = a + b;

endmodule

module add_4b_arb (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    input  logic [3:0] req0_x,
    input  logic [3:0] req0_y,
    output logic       req0_ready,

    input  logic       req1_valid,
    input  logic [3:0] req1_x,
    input  logic [3:0] req1_y,
    output logic       req1_ready,

    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_sum,
    output logic       res_id
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e     state_q;
    logic [3:0] res_sum_q;
    logic       res_id_q;
    logic       last_id_q;

    logic       grant0;
    logic       grant1;
    logic       slot_free;
    logic       handshake;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_sum;

    // On a tie the requester not served last wins; a lone valid always wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_id_q);
        grant1 = req1_valid & (~req0_valid | ~last_id_q);
    end

    assign slot_free  = (state_q == StIdle) | res_ready;
    assign req0_ready = slot_free & grant0;
    assign req1_ready = slot_free & grant1;
    assign handshake  = req0_ready | req1_ready;

    assign add_a = grant1 ? req1_x : req0_x;
    assign add_b = grant1 ? req1_y : req0_y;

    add_4b u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            res_sum_q <= 4'b0000;
            res_id_q  <= 1'b0;
            last_id_q <= 1'b1;
        end else if (handshake) begin
            state_q   <= StHold;
            res_sum_q <= add_sum;
            res_id_q  <= grant1;
            last_id_q <= grant1;
        end else if (state_q == StHold && res_ready) begin
            state_q <= StIdle;
        end
    end

    assign res_valid = (state_q == StHold);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_add_4b_arb.sv
// Directed bench for add_4b_arb: arbitration, wrap-around, backpressure,
// reset in HOLD and starvation-freedom.

module tb_add_4b_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_x, req0_y, req1_x, req1_y;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_ready, res_id;
    logic [3:0] res_sum;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    add_4b_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic v, input logic [3:0] s,
                           input logic id);
        chk({tag, ".valid"}, {7'd0, res_valid}, {7'd0, v});
        chk({tag, ".sum"}, {4'd0, res_sum}, {4'd0, s});
        chk({tag, ".id"}, {7'd0, res_id}, {7'd0, id});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".ready0"}, {7'd0, req0_ready}, {7'd0, r0});
        chk({tag, ".ready1"}, {7'd0, req1_ready}, {7'd0, r1});
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_x = 4'd0; req0_y = 4'd0;
        req1_valid = 1'b0; req1_x = 4'd0; req1_y = 4'd0;
        res_ready = 1'b0;

        // Reset state
        #12;
        chk_res("reset", 1'b0, 4'h0, 1'b0);
        chk_rdy("reset", 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;

        // Single requester, handshake on the first edge after release
        req0_valid = 1'b1; req0_x = 4'b1000; req0_y = 4'b1001; res_ready = 1'b1;
        #1;
        chk_rdy("single", 1'b1, 1'b0);
        tick();
        req0_valid = 1'b0;
        chk_res("single", 1'b1, 4'b0001, 1'b0);

        // Wrap-around from requester 1, accepted while the slot drains
        req1_valid = 1'b1; req1_x = 4'b1101; req1_y = 4'b0110;
        #1;
        chk_rdy("wrap1", 1'b0, 1'b1);
        tick();
        chk_res("wrap1", 1'b1, 4'b0011, 1'b1);
        req1_x = 4'b1111; req1_y = 4'b0001;
        tick();
        chk_res("wrap2", 1'b1, 4'b0000, 1'b1);
        req1_valid = 1'b0;
        tick();
        chk("drain.valid", {7'd0, res_valid}, 8'd0);

        // Tie after reset: req0, req1, req0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_x = 4'd2; req0_y = 4'd3;
        req1_valid = 1'b1; req1_x = 4'd4; req1_y = 4'd5;
        #1;
        chk_rdy("tie1", 1'b1, 1'b0);
        tick();
        chk_res("tie1", 1'b1, 4'b0101, 1'b0);
        chk_rdy("tie2", 1'b0, 1'b1);
        tick();
        chk_res("tie2", 1'b1, 4'b1001, 1'b1);
        chk_rdy("tie3", 1'b1, 1'b0);
        tick();
        chk_res("tie3", 1'b1, 4'b0101, 1'b0);

        // Backpressure with both valid
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy("bp", 1'b0, 1'b0);
            tick();
            chk_res("bp", 1'b1, 4'b0101, 1'b0);
        end
        res_ready = 1'b1;
        #1;
        chk_rdy("bp_release", 1'b0, 1'b1);
        tick();
        chk_res("bp_release", 1'b1, 4'b1001, 1'b1);

        // Reset asserted in HOLD discards the result at once
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_res("rst_hold", 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rst_hold.after", {7'd0, res_valid}, 8'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk_rdy("rst_tie", 1'b1, 1'b0);
        tick();
        chk_res("rst_tie", 1'b1, 4'b0101, 1'b0);

        // Starvation: req0 always valid, req1 raised intermittently
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g <= i; g++) tick();
            req1_valid = 1'b1; req1_x = 4'(i); req1_y = 4'd7;
            #1;
            waited = 0;
            while (!req1_ready && waited < 4) begin
                tick();
                waited++;
            end
            chk("starve.slots", {7'd0, (waited < 2)}, 8'd1);
            tick();
            req1_valid = 1'b0;
            chk("starve.id", {7'd0, res_id}, 8'd1);
            chk("starve.sum", {4'd0, res_sum}, {4'd0, 4'(i + 7)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
